// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and receiver state encoding
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous input, resets to 1 (idle line)
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    // shift the raw input through the flop chain
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) ff <= '1;
        else         ff <= (ff << 1) | N'(d);
    end

    assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, even parity, one stop bit
module uart_rx
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic [31:0]               clk_div_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_data_o,
    output logic                      rx_valid_o,
    output logic                      parity_err_o,
    output logic                      frame_err_o,
    output logic                      busy_o
);

    localparam int IW = $clog2(UART_DATA_BITS);

    uart_rx_state_e            state, next;
    logic                      rxs;
    logic [31:0]               cnt;
    logic [IW-1:0]             idx;
    logic [UART_DATA_BITS-1:0] sh;
    logic                      acc, pbad;
    logic                      hit_half, hit_full, sample, done;

    uart_sync #(.N(UART_SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rstn_i (rstn_i),
        .d      (rx_i),
        .q      (rxs)
    );

    assign hit_half = cnt == (clk_div_i >> 1);
    assign hit_full = cnt == clk_div_i;

    // state register
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= next;
    end

    // next-state logic: start at half bit, the rest at full bit periods
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = rxs ? IDLE : START;
            START:   next = hit_half ? (rxs ? IDLE : DATA) : START;
            DATA:    next = (hit_full && idx == IW'(UART_DATA_BITS - 1)) ? PARITY : DATA;
            PARITY:  next = hit_full ? STOP : PARITY;
            STOP:    next = hit_full ? (rxs ? IDLE : BREAK) : STOP;
            BREAK:   next = rxs ? IDLE : BREAK;
            default: next = IDLE;
        endcase
    end

    // decoded controls: sample strobe, frame completion, busy
    always_comb begin
        busy_o = state != IDLE;
        sample = state == START ? hit_half :
                 (state == DATA || state == PARITY || state == STOP) ? hit_full : 1'b0;
        done   = state == STOP && hit_full;
    end

    // bit timer, data shift register, parity accumulation and output registers
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            acc          <= 1'b0;
            pbad         <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            cnt        <= (state != next || sample) ? '0 : cnt + 32'd1;
            rx_valid_o <= done;
            if (state == START && hit_half) begin
                idx <= '0;
                acc <= 1'b0;
            end
            if (state == DATA && hit_full) begin
                sh  <= {rxs, sh[UART_DATA_BITS-1:1]};
                acc <= acc ^ rxs;
                idx <= idx + 1'b1;
            end
            if (state == PARITY && hit_full) pbad <= rxs ^ acc;
            if (done) begin
                rx_data_o    <= sh;
                parity_err_o <= pbad;
                frame_err_o  <= ~rxs;
            end
        end
    end

endmodule
